// File: rtl/frame_pkg.sv
// Shared frame-buffer definitions: writer FSM states, pixel packing and the
// default frame geometry also used by the video read side.
package frame_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SWAP = 2'd2
  } frame_state_t;

  localparam int CHAN_W         = 4;
  localparam int PIX_DATA_W     = 3 * CHAN_W;
  localparam int COORD_W        = 11;
  localparam int DEFAULT_WIDTH  = 320;
  localparam int DEFAULT_HEIGHT = 180;

  function automatic logic [PIX_DATA_W-1:0] pack_rgb(
    input logic [CHAN_W-1:0] r,
    input logic [CHAN_W-1:0] g,
    input logic [CHAN_W-1:0] b
  );
    return {r, g, b};
  endfunction

  // Unsigned compare at full width so oversized coordinates never alias.
  function automatic logic in_frame(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 w,
    input int                 h
  );
    return (32'(x) < 32'(w)) && (32'(y) < 32'(h));
  endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Two-stage pipeline turning (bank, x, y, colour) into a linear BRAM
// write address and packed data word, carrying range and valid flags along.
module pixel_addr_gen
  import frame_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int ADDR_W = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [COORD_W-1:0]    x_in,
  input  logic [COORD_W-1:0]    y_in,
  input  logic                  bank_in,
  input  logic [CHAN_W-1:0]     r_in,
  input  logic [CHAN_W-1:0]     g_in,
  input  logic [CHAN_W-1:0]     b_in,
  input  logic                  valid_in,
  output logic [ADDR_W-1:0]     addr,
  output logic [PIX_DATA_W-1:0] data,
  output logic                  in_range,
  output logic                  valid
);

  localparam logic [31:0] FRAME_PIX = 32'(WIDTH * HEIGHT);
  localparam logic [31:0] WIDTH_U   = 32'(WIDTH);

  logic [31:0]           y_mul_reg, y_mul_next;
  logic [COORD_W-1:0]    x_s1_reg;
  logic [PIX_DATA_W-1:0] data_s1_reg;
  logic                  range_s1_reg, valid_s1_reg, bank_s1_reg;

  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [PIX_DATA_W-1:0] data_reg;
  logic                  range_reg, valid_reg;

  // The multiply lands in stage 1 and the bank/column adds in stage 2.
  always_comb begin
    y_mul_next = 32'(y_in) * WIDTH_U;
    addr_next  = ADDR_W'((bank_s1_reg ? FRAME_PIX : 32'd0) + y_mul_reg + 32'(x_s1_reg));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      y_mul_reg    <= '0;
      x_s1_reg     <= '0;
      data_s1_reg  <= '0;
      range_s1_reg <= 1'b0;
      valid_s1_reg <= 1'b0;
      bank_s1_reg  <= 1'b0;
    end else begin
      y_mul_reg    <= y_mul_next;
      x_s1_reg     <= x_in;
      data_s1_reg  <= pack_rgb(r_in, g_in, b_in);
      range_s1_reg <= in_frame(x_in, y_in, WIDTH, HEIGHT);
      valid_s1_reg <= valid_in;
      bank_s1_reg  <= bank_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      range_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      addr_reg  <= addr_next;
      data_reg  <= data_s1_reg;
      range_reg <= range_s1_reg;
      valid_reg <= valid_s1_reg;
    end
  end

  assign addr     = addr_reg;
  assign data     = data_reg;
  assign in_range = range_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/pixel_frame_writer.sv
// Writes the pixel stream into a double-buffered frame BRAM and swaps
// banks on the first vsync rising edge after a full frame has been written.
module pixel_frame_writer
  import frame_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int ADDR_W = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [COORD_W-1:0]    x_in,
  input  logic [COORD_W-1:0]    y_in,
  input  logic [CHAN_W-1:0]     r_in,
  input  logic [CHAN_W-1:0]     g_in,
  input  logic [CHAN_W-1:0]     b_in,
  input  logic                  valid_in,
  input  logic                  vsync_in,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIX_DATA_W-1:0] wr_data,
  output logic                  wr_en,
  output logic                  rd_bank,
  output logic                  frame_done,
  output logic [15:0]           drop_count
);

  localparam int               FRAME_PIX  = WIDTH * HEIGHT;
  localparam int               CNT_W      = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIX - 1);

  frame_state_t     state_reg, state_next;
  logic             wr_bank_reg, wr_bank_next;
  logic [CNT_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic             frame_done_reg, frame_done_next;
  logic [15:0]      drop_count_reg, drop_count_next;
  logic             vsync_prev_reg;

  logic vsync_rise, range_ok, accept, drop, swap_start;
  logic gen_in_range, gen_valid;

  assign vsync_rise = vsync_in && !vsync_prev_reg;
  assign range_ok   = in_frame(x_in, y_in, WIDTH, HEIGHT);
  assign accept     = valid_in && range_ok && (state_reg == FILL);
  assign drop       = valid_in && !accept;
  assign swap_start = (state_reg == WAIT) && vsync_rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (accept && (pix_cnt_reg == FRAME_LAST)) state_next = WAIT;
      WAIT:    if (vsync_rise) state_next = SWAP;
      SWAP:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Bank toggle and frame_done register together so both appear in the SWAP cycle.
  always_comb begin
    pix_cnt_next    = pix_cnt_reg;
    wr_bank_next    = wr_bank_reg ^ swap_start;
    frame_done_next = swap_start;
    drop_count_next = drop_count_reg;
    if (state_reg == SWAP) begin
      pix_cnt_next = '0;
    end else if (accept) begin
      pix_cnt_next = pix_cnt_reg + CNT_W'(1);
    end
    if (drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_next = drop_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_bank_reg    <= 1'b0;
      pix_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
      drop_count_reg <= '0;
      vsync_prev_reg <= 1'b0;
    end else begin
      wr_bank_reg    <= wr_bank_next;
      pix_cnt_reg    <= pix_cnt_next;
      frame_done_reg <= frame_done_next;
      drop_count_reg <= drop_count_next;
      vsync_prev_reg <= vsync_in;
    end
  end

  // Only pixels arriving in FILL enter the pipe as valid; range gates the write.
  pixel_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .x_in     (x_in),
    .y_in     (y_in),
    .bank_in  (wr_bank_reg),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .valid_in (valid_in && (state_reg == FILL)),
    .addr     (wr_addr),
    .data     (wr_data),
    .in_range (gen_in_range),
    .valid    (gen_valid)
  );

  assign wr_en      = gen_valid && gen_in_range;
  assign rd_bank    = ~wr_bank_reg;
  assign frame_done = frame_done_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer on a 4x2 frame: raster table, directed
// corner sequences and randomized traffic checked against a frame-level model.
module tb_pixel_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;
  localparam int FP = W * H;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] x_in = '0, y_in = '0;
  logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        valid_in = 1'b0, vsync_in = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en, rd_bank, frame_done;
  logic [15:0] drop_count;

  pixel_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .valid_in   (valid_in),
    .vsync_in   (vsync_in),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rd_bank    (rd_bank),
    .frame_done (frame_done),
    .drop_count (drop_count)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;

  // Frame-level reference: phase 0 filling, 1 waiting for vsync, 2 swapping.
  typedef struct { bit v; int addr; int data; } exp_wr_t;
  exp_wr_t pipe[$];
  int m_phase, m_cnt, m_drops;
  bit m_bank, m_prev_vs, m_fd;

  typedef struct {
    logic v; int x; int y; logic [11:0] rgb; logic vs;
    logic e_en; logic [3:0] e_addr; logic [11:0] e_data;
    logic e_rd_bank; logic e_fd; logic [15:0] e_drop;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s tick=%0d got=%0h expected=%0h", name, tick_no, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_drops = 0;
    m_bank = 0; m_prev_vs = 0; m_fd = 0;
    pipe.delete();
    pipe.push_back('{v: 0, addr: 0, data: 0});
  endtask

  task automatic tick(input logic v, input int x, input int y, input logic [11:0] rgb,
                      input logic vs, input logic rst);
    exp_wr_t e, nw;
    bit edge_seen, inr;
    valid_in = v; x_in = 11'(x); y_in = 11'(y);
    r_in = rgb[11:8]; g_in = rgb[7:4]; b_in = rgb[3:0];
    vsync_in = vs; rst_in = rst;
    nw = '{v: 0, addr: 0, data: 0};
    if (rst) begin
      model_reset();
      e = '{v: 0, addr: 0, data: 0};
    end else begin
      edge_seen = vs && !m_prev_vs;
      m_prev_vs = vs;
      inr = (x < W) && (y < H);
      m_fd = 0;
      if (m_phase == 0) begin
        if (v && inr) begin
          nw = '{v: 1, addr: (m_bank ? FP : 0) + y * W + x, data: int'(rgb)};
          m_cnt++;
          if (m_cnt == FP) m_phase = 1;
        end else if (v) begin
          m_drops = (m_drops < 65535) ? m_drops + 1 : m_drops;
        end
      end else begin
        if (v) m_drops = (m_drops < 65535) ? m_drops + 1 : m_drops;
        if (m_phase == 2) begin
          m_phase = 0; m_cnt = 0;
        end else if (edge_seen) begin
          m_phase = 2; m_bank = !m_bank; m_fd = 1;
        end
      end
      e = pipe.pop_front();
      pipe.push_back(nw);
    end
    @(posedge clk_in);
    #1;
    tick_no++;
    if (wr_en) $display("write tick=%0d addr=%0d data=%03h", tick_no, wr_addr, wr_data);
    check("wr_en", 32'(wr_en), 32'(e.v));
    if (e.v) begin
      check("wr_addr", 32'(wr_addr), e.addr);
      check("wr_data", 32'(wr_data), e.data);
    end
    check("rd_bank", 32'(rd_bank), 32'(!m_bank));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("drop_count", 32'(drop_count), m_drops);
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 12'h000, vs, 1'b0);
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] rgb, input logic vs);
    tick(1'b1, x, y, rgb, vs, 1'b0);
  endtask

  initial begin
    logic vs_r;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 12'h000, 1'b0, 1'b1);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_rd_bank", 32'(rd_bank), 1);

    // Raster fill table: write for row r appears in row r+1
    for (int r = 0; r < 10; r++) begin
      vecs[r].v = (r < 8);
      vecs[r].x = (r < 8) ? r % W : 0;
      vecs[r].y = (r < 8) ? r / W : 0;
      vecs[r].rgb = 12'(r + 1);
      vecs[r].vs = 1'b0;
      vecs[r].e_en = (r >= 1) && (r <= 8);
      vecs[r].e_addr = 4'(r - 1);
      vecs[r].e_data = 12'(r);
      vecs[r].e_rd_bank = 1'b1;
      vecs[r].e_fd = 1'b0;
      vecs[r].e_drop = 16'd0;
    end
    for (int r = 0; r < 10; r++) begin
      tick(vecs[r].v, vecs[r].x, vecs[r].y, vecs[r].rgb, vecs[r].vs, 1'b0);
      check("tbl_wr_en", 32'(wr_en), 32'(vecs[r].e_en));
      if (vecs[r].e_en) begin
        check("tbl_wr_addr", 32'(wr_addr), 32'(vecs[r].e_addr));
        check("tbl_wr_data", 32'(wr_data), 32'(vecs[r].e_data));
      end
      check("tbl_rd_bank", 32'(rd_bank), 32'(vecs[r].e_rd_bank));
      check("tbl_frame_done", 32'(frame_done), 32'(vecs[r].e_fd));
      check("tbl_drop", 32'(drop_count), 32'(vecs[r].e_drop));
    end

    // Swap on vsync rise, then first pixel of next frame lands in bank 1
    idle(2, 1'b0);
    tick(1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    check("swap_frame_done", 32'(frame_done), 1);
    check("swap_rd_bank", 32'(rd_bank), 0);
    idle(1, 1'b1);
    check("frame_done_one_cycle", 32'(frame_done), 0);
    pix(1, 1, 12'h5A3, 1'b0);
    idle(1, 1'b0);
    check("bank1_wr_en", 32'(wr_en), 1);
    check("bank1_addr_13", 32'(wr_addr), 13);

    // Out of range pixels
    pix(4, 0, 12'h111, 1'b0);
    pix(0, 2, 12'h222, 1'b0);
    idle(2, 1'b0);
    check("oor_drop_count", 32'(drop_count), 2);

    // Coincident last pixel and vsync edge: no swap until a later edge
    for (int k = 1; k < 7; k++) pix(k % W, k / W, 12'(12'h300 + k), 1'b0);
    pix(3, 1, 12'h3FF, 1'b1);
    idle(1, 1'b1);
    check("coinc_write", 32'(wr_en), 1);
    check("coinc_no_swap", 32'(frame_done), 0);
    idle(3, 1'b1);
    idle(5, 1'b0);
    tick(1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    check("late_swap_frame_done", 32'(frame_done), 1);
    check("late_swap_rd_bank", 32'(rd_bank), 1);

    // Overflow: drops in WAIT and in the SWAP cycle
    idle(1, 1'b1);
    for (int k = 0; k < FP; k++) pix(k % W, k / W, 12'(12'h700 + k), 1'b0);
    idle(1, 1'b0);
    for (int k = 0; k < 5; k++) pix(k % W, 0, 12'hBAD, 1'b0);
    tick(1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    pix(2, 1, 12'hBEE, 1'b1);
    idle(2, 1'b1);
    check("overflow_drop_count", 32'(drop_count), 8);
    check("overflow_rd_bank", 32'(rd_bank), 0);

    // Reset mid-frame with a write in flight
    for (int k = 0; k < 3; k++) pix(k, 0, 12'(12'h900 + k), 1'b0);
    tick(1'b1, 3, 0, 12'h903, 1'b0, 1'b1);
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_rd_bank", 32'(rd_bank), 1);
    check("midrst_drop", 32'(drop_count), 0);
    pix(0, 0, 12'hC01, 1'b0);
    idle(1, 1'b0);
    check("refill_wr_en", 32'(wr_en), 1);
    check("refill_addr0", 32'(wr_addr), 0);
    for (int k = 1; k < FP; k++) pix(k % W, k / W, 12'(12'hC01 + k), 1'b0);
    idle(2, 1'b0);

    // Randomized traffic against the model
    vs_r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) vs_r = ~vs_r;
      tick(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
           12'($urandom), vs_r, 1'($urandom_range(0, 399) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
